// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU (option: DIV_EARLY_OUT_EN)
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signedDiv_i,
    input  logic [DATA_W-1:0]     opNum1_i,
    input  logic [DATA_W-1:0]     opNum2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [DATA_W-1:0]      rem, rem_n;
    logic [DATA_W-1:0]      quo, quo_n;
    logic [DATA_W-1:0]      dvs, dvs_n;
    logic                   neg_quo, neg_quo_n;
    logic                   neg_rem, neg_rem_n;
    logic [2*DATA_W-1:0]    result_n;
    logic                   ready_n;

    logic [DATA_W-1:0]      mag1, mag2;
    logic [2*DATA_W-1:0]    shifted;
    logic [DATA_W:0]        trial;
    logic [DATA_W-1:0]      quo_fix, rem_fix;

    // Operand magnitudes, one restoring step and the final sign correction
    always_comb begin
        mag1    = (signedDiv_i && opNum1_i[DATA_W-1]) ? (~opNum1_i + 1'b1) : opNum1_i;
        mag2    = (signedDiv_i && opNum2_i[DATA_W-1]) ? (~opNum2_i + 1'b1) : opNum2_i;
        shifted = {rem, quo} << 1;
        trial   = {1'b0, shifted[2*DATA_W-1:DATA_W]} - {1'b0, dvs};
        quo_fix = neg_quo ? (~quo + 1'b1) : quo;
        rem_fix = neg_rem ? (~rem + 1'b1) : rem;
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rem_n     = rem;
        quo_n     = quo;
        dvs_n     = dvs;
        neg_quo_n = neg_quo;
        neg_rem_n = neg_rem;
        result_n  = result_o;
        ready_n   = ready_o;
        case (state)
            FREE: begin
                result_n = '0;
                ready_n  = 1'b0;
                if (start_i && !annul_i) begin
                    neg_quo_n = signedDiv_i && (opNum1_i[DATA_W-1] ^ opNum2_i[DATA_W-1]);
                    neg_rem_n = signedDiv_i && opNum1_i[DATA_W-1];
                    dvs_n     = mag2;
                    rem_n     = '0;
                    quo_n     = mag1;
                    cnt_n     = '0;
                    if (mag2 == '0) begin
                        state_n = BY_ZERO;
                    end else begin
                        state_n = ON;
`ifdef DIV_EARLY_OUT_EN
                        // Small dividend: skip the iterations by parking the dividend
                        // as the remainder and jumping to the final correction step
                        if (mag1 < mag2) begin
                            rem_n = mag1;
                            quo_n = '0;
                            cnt_n = CNT_LAST;
                        end
`endif
                    end
                end
            end
            BY_ZERO: begin
                if (annul_i) begin
                    state_n = FREE;
                end else begin
                    state_n  = END;
                    result_n = '0;
                    ready_n  = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_n = FREE;
                end else if (cnt == CNT_LAST) begin
                    state_n  = END;
                    result_n = {rem_fix, quo_fix};
                    ready_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (!trial[DATA_W]) begin
                        rem_n = trial[DATA_W-1:0];
                        quo_n = {shifted[DATA_W-1:1], 1'b1};
                    end else begin
                        rem_n = shifted[2*DATA_W-1:DATA_W];
                        quo_n = {shifted[DATA_W-1:1], 1'b0};
                    end
                end
            end
            END: begin
                if (!start_i) begin
                    state_n  = FREE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end
            end
            default: state_n = FREE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FREE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            quo      <= quo_n;
            dvs      <= dvs_n;
            neg_quo  <= neg_quo_n;
            neg_rem  <= neg_rem_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

endmodule
